// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, mux selects,
// ALUOp codes, FSM state encoding and the packed bundle of control strobes.
package mips_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mips_mem_wait_ctr.sv
// Saturating count of consecutive cycles a memory request has waited, plus a
// sticky timeout flag; 1-cycle registered, never stalls the FSM.
module mips_mem_wait_ctr #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ready,
  output logic mem_timeout
);

  localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MEM_WAIT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          waiting;

  assign waiting = mem_req & ~mem_ready;

  // Any cycle that is not a stalled request (ready, or another state) clears.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (waiting) begin
      cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
      if (cnt_d == MAX_CNT) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath; LW 5, SW/RTYPE/ADDI 4, BEQ/J 3
// cycles, plus one per cycle spent waiting for mem_ready in FETCH/MEMRD/MEMWR.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal_op,
  output logic       mem_timeout
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_o;
  logic   timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      // Branch target is computed speculatively here into ALUOut.
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_d         = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ready) begin
          ctrl.mem_write = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_JEX: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
        state_d       = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Outputs are killed combinationally so nothing leaks out while reset is high.
  always_comb begin
    ctrl_o = ctrl;
    if (reset) begin
      ctrl_o = '0;
    end
  end

  mips_mem_wait_ctr #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait_ctr (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (ctrl_o.mem_req),
    .mem_ready  (mem_ready),
    .mem_timeout(timeout)
  );

  assign mem_req     = ctrl_o.mem_req;
  assign MemWrite    = ctrl_o.mem_write;
  assign IRWrite     = ctrl_o.ir_write;
  assign IorD        = ctrl_o.iord;
  assign RegDst      = ctrl_o.reg_dst;
  assign MemtoReg    = ctrl_o.mem_to_reg;
  assign RegWrite    = ctrl_o.reg_write;
  assign ALUSrcA     = ctrl_o.alu_src_a;
  assign ALUSrcB     = ctrl_o.alu_src_b;
  assign ALUOp       = ctrl_o.alu_op;
  assign PCSrc       = ctrl_o.pc_src;
  assign PCEn        = ctrl_o.pc_write | (ctrl_o.branch & zero);
  assign illegal_op  = ctrl_o.illegal_op;
  assign mem_timeout = timeout & ~reset;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scenario bench for the multicycle control FSM: expected output vectors are
// queued as each cycle is driven and compared at the following falling edge.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;
  logic       mem_req, MemWrite, IRWrite, IorD, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, illegal_op, mem_timeout;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_RTYPEEX = 6, S_RTYPEWB = 7, S_BEQEX = 8, S_ADDIEX = 9,
                 S_ADDIWB = 10, S_JEX = 11;

  int          total = 0;
  int          bad = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  mips_multicycle_control #(.MEM_WAIT_MAX(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .IorD(IorD),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  function automatic logic [16:0] out_vec();
    return {mem_req, MemWrite, IRWrite, IorD, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, mem_timeout};
  endfunction

  // Reference table of per-state outputs, taken from the state descriptions.
  function automatic logic [16:0] expect_out(input int st, input logic [5:0] op,
                                             input logic rdy, input logic z, input logic to);
    logic mreq, mw, irw, iord, rdst, m2r, rw, srca, pcen, ill;
    logic [1:0] srcb, aop, pcs;
    {mreq, mw, irw, iord, rdst, m2r, rw, srca, pcen, ill} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      S_FETCH:   begin mreq = 1; srcb = 2'b01; irw = rdy; pcen = rdy; end
      S_DECODE:  begin
        srcb = 2'b11;
        ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
      end
      S_MEMADR:  begin srca = 1; srcb = 2'b10; end
      S_MEMRD:   begin mreq = 1; iord = 1; end
      S_MEMWB:   begin m2r = 1; rw = 1; end
      S_MEMWR:   begin mreq = 1; iord = 1; mw = rdy; end
      S_RTYPEEX: begin srca = 1; aop = 2'b10; end
      S_RTYPEWB: begin rdst = 1; rw = 1; end
      S_BEQEX:   begin srca = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
      S_ADDIEX:  begin srca = 1; srcb = 2'b10; end
      S_ADDIWB:  begin rw = 1; end
      S_JEX:     begin pcs = 2'b10; pcen = 1; end
      default:   ;
    endcase
    return {mreq, mw, irw, iord, rdst, m2r, rw, srca, srcb, aop, pcs, pcen, ill, to};
  endfunction

  // Called at posedge+1: drives this cycle's inputs, queues the expectation, moves to negedge.
  task automatic drive_cycle(input int st, input logic rdy, input logic z, input logic to);
    mem_ready = rdy;
    zero = z;
    exp_q.push_back(expect_out(st, opcode, rdy, z, to));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] got, want;
    int st[3] = '{S_FETCH, S_DECODE, S_MEMADR};
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(17'h0);
    got = out_vec(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset_hold got=%h want=%h", got, want); end
    reset = 1'b0;
    opcode = 6'b101011;
    foreach (st[i]) begin
      drive_cycle(st[i], 1'b1, 1'b0, 1'b0);
      got = out_vec(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset_sw_lead cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    exp_q.push_back(expect_out(S_MEMWR, opcode, 1'b1, 1'b0, 1'b0));
    #1;
    got = out_vec(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset_memwr_before got=%h want=%h", got, want); end
    reset = 1'b1;
    exp_q.push_back(17'h0);
    #1;
    got = out_vec(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset_mid_memwr got=%h want=%h", got, want); end
    @(posedge clk); #1;
    reset = 1'b0;
    drive_cycle(S_FETCH, 1'b0, 1'b0, 1'b0);
    got = out_vec(); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset_release_fetch got=%h want=%h", got, want); end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    logic [16:0] got, want;
    int st[5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
    opcode = 6'b100011;
    foreach (st[i]) begin
      drive_cycle(st[i], 1'b1, 1'b0, 1'b0);
      got = out_vec(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL lw cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [16:0] got, want;
    int st[4] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
    opcode = 6'b101011;
    foreach (st[i]) begin
      drive_cycle(st[i], 1'b1, 1'b0, 1'b0);
      got = out_vec(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL sw cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [16:0] got, want;
    int st[5] = '{S_FETCH, S_DECODE, S_RTYPEEX, S_RTYPEWB, S_FETCH};
    bit rd[5] = '{1, 1, 1, 1, 0};
    opcode = 6'b000000;
    foreach (st[i]) begin
      drive_cycle(st[i], rd[i], 1'b0, 1'b0);
      got = out_vec(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL rtype cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq(input logic z);
    logic [16:0] got, want;
    int st[3] = '{S_FETCH, S_DECODE, S_BEQEX};
    opcode = 6'b000100;
    foreach (st[i]) begin
      drive_cycle(st[i], 1'b1, z, 1'b0);
      got = out_vec(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL beq_z%0d cyc%0d got=%h want=%h", z, i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi_j();
    logic [16:0] got, want;
    int st[7] = '{S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB, S_FETCH, S_DECODE, S_JEX};
    logic [5:0] op[7] = '{6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b000010, 6'b000010, 6'b000010};
    foreach (st[i]) begin
      opcode = op[i];
      drive_cycle(st[i], 1'b1, 1'b0, 1'b0);
      got = out_vec(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL addi_j cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [16:0] got, want;
    int st[3] = '{S_FETCH, S_DECODE, S_FETCH};
    bit rd[3] = '{1, 1, 0};
    opcode = 6'b111111;
    foreach (st[i]) begin
      drive_cycle(st[i], rd[i], 1'b0, 1'b0);
      got = out_vec(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL illegal cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_stall();
    logic [16:0] got, want;
    int st[8] = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_JEX};
    bit rd[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    bit to[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    do_reset();
    opcode = 6'b000010;
    foreach (st[i]) begin
      drive_cycle(st[i], rd[i], 1'b0, to[i]);
      got = out_vec(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL fetch_stall cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait_clear();
    logic [16:0] got, want;
    int st[9] = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
    bit rd[9] = '{0, 0, 1, 1, 1, 0, 0, 1, 1};
    do_reset();
    opcode = 6'b100011;
    foreach (st[i]) begin
      drive_cycle(st[i], rd[i], 1'b0, 1'b0);
      got = out_vec(); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL wait_clear cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq(1'b1);
    test_beq(1'b0);
    test_addi_j();
    test_illegal();
    test_fetch_stall();
    test_wait_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
